// File: rtl/instruction_encoder.sv
// instruction_encoder
//   Program-loader front end. Encodes decoded LEGv8-subset instruction fields
//   into 32-bit machine words and streams them, with sequential byte
//   addresses starting at BASE_ADDR, to an instruction-memory write port.
//
//   Ports
//     clk, reset        rising-edge clock; synchronous active-high reset
//     restart           drop held word, rewind address/count
//     in_valid/in_ready field-bundle handshake (op, rd, rn, rm, shamt, imm*)
//     out_valid/out_ready, out_data, out_addr   memory write handshake
//     word_count, full  words accepted since reset/restart; count == DEPTH
//     err_illegal       one-cycle pulse when an illegal op is consumed
//     err_sticky        set on any illegal op, cleared only by reset
module instruction_encoder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       restart,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 op,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rn,
  input  logic [4:0]                 rm,
  input  logic [5:0]                 shamt,
  input  logic [11:0]                imm12,
  input  logic [8:0]                 imm9,
  input  logic [18:0]                imm19,
  input  logic [25:0]                imm26,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [$clog2(DEPTH+1)-1:0] word_count,
  output logic                       full,
  output logic                       err_illegal,
  output logic                       err_sticky
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   next_addr;
  logic [31:0]         enc;
  logic                legal;
  logic                accept;
  logic                acc_legal;
  logic                transfer;

  // Field packing; the legal flag rides along so illegal ops share the
  // same accept path but never produce a word.
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (op)
      4'd0: enc = {10'b1001000100, imm12, rn, rd};
      4'd1: enc = {11'b10101011000, rm, shamt, rn, rd};
      4'd2: enc = {11'b11101011000, rm, shamt, rn, rd};
      4'd3: enc = {6'b000101, imm26};
      4'd4: enc = {6'b100101, imm26};
      4'd5: enc = {8'b01010100, imm19, rd};
      4'd6: enc = {8'b10110100, imm19, rd};
      // The decoder takes the branch target from [4:0], so rn fills both slots.
      4'd7: enc = {11'b11010110000, 5'b11111, 6'b000000, rn, rn};
      4'd8: enc = {11'b11111000010, imm9, 2'b00, rn, rd};
      4'd9: enc = {11'b11111000000, imm9, 2'b00, rn, rd};
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  assign out_valid = (state == HOLD);
  assign full      = (word_count == LIMIT);
  assign transfer  = out_valid && out_ready;

  // Also blocked while the last permitted word is still held, so the
  // memory is never written past DEPTH words.
  assign in_ready  = (state != FULL) && !full && (!out_valid || out_ready) && !restart;
  assign accept    = in_valid && in_ready;
  assign acc_legal = accept && legal;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (acc_legal) state_next = HOLD;
      HOLD: begin
        if (transfer) begin
          if (acc_legal)      state_next = HOLD;
          else if (full)      state_next = FULL;
          else                state_next = IDLE;
        end
      end
      FULL:    state_next = FULL;
      default: state_next = IDLE;
    endcase
    if (restart) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data    <= '0;
      out_addr    <= BASE;
      next_addr   <= BASE;
      word_count  <= '0;
      err_illegal <= 1'b0;
      err_sticky  <= 1'b0;
    end else if (restart) begin
      next_addr   <= BASE;
      word_count  <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (acc_legal) begin
        out_data   <= enc;
        out_addr   <= next_addr;
        next_addr  <= next_addr + ADDR_W'(4);
        word_count <= word_count + CNT_W'(1);
      end
      err_illegal <= accept && !legal;
      if (accept && !legal) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

  localparam int unsigned TB_DEPTH = 4;
  localparam int unsigned AW       = 12;
  localparam int unsigned CW       = $clog2(TB_DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, restart, in_valid, in_ready;
  logic [3:0]    op;
  logic [4:0]    rd, rn, rm;
  logic [5:0]    shamt;
  logic [11:0]   imm12;
  logic [8:0]    imm9;
  logic [18:0]   imm19;
  logic [25:0]   imm26;
  logic          out_valid, out_ready;
  logic [31:0]   out_data;
  logic [AW-1:0] out_addr;
  logic [CW-1:0] word_count;
  logic          full, err_illegal, err_sticky;

  typedef struct packed {
    logic [31:0]   d;
    logic [AW-1:0] a;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_addr = 0;
  int   exp_cnt  = 0;

  instruction_encoder #(.DEPTH(TB_DEPTH), .ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .shamt(shamt),
    .imm12(imm12), .imm9(imm9), .imm19(imm19), .imm26(imm26),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .word_count(word_count), .full(full),
    .err_illegal(err_illegal), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Monitor: every memory-side transfer is compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", out_data, 32'hXXXXXXXX);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_addr", {20'd0, out_addr}, {20'd0, e.a});
        end
      end
    end
  end

  // Called at posedge+#1. Returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [4:0] d_rd, input logic [4:0] d_rn,
                      input logic [4:0] d_rm, input logic [5:0] d_sh, input logic [11:0] d_i12,
                      input logic [8:0] d_i9, input logic [18:0] d_i19, input logic [25:0] d_i26,
                      input logic [31:0] exp_word, input bit is_legal);
    bit got = 0;
    op = o; rd = d_rd; rn = d_rn; rm = d_rm; shamt = d_sh;
    imm12 = d_i12; imm9 = d_i9; imm19 = d_i19; imm26 = d_i26;
    in_valid = 1'b1;
    for (int unsigned i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (is_legal) begin
      exp_q.push_back('{d: exp_word, a: AW'(exp_addr)});
      exp_addr += 4;
      exp_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("word_count", {29'd0, word_count}, exp_cnt);
    chk("out_valid_latency", {31'd0, out_valid}, {31'd0, is_legal});
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !out_valid) return;
      @(posedge clk); #1;
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic do_restart();
    drain();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    exp_addr = 0;
    exp_cnt  = 0;
    chk("restart_count", {29'd0, word_count}, 32'd0);
    chk("restart_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; rd = '0; rn = '0; rm = '0; shamt = '0;
    imm12 = '0; imm9 = '0; imm19 = '0; imm26 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_addr", {20'd0, out_addr}, 32'd0);
    chk("rst_word_count", {29'd0, word_count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_err", {30'd0, err_illegal, err_sticky}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADDI, SUBS, LDUR at 0,4,8
    send(4'd0, 5'd3, 5'd1, 5'd0, 6'd0, 12'd5, 9'd0, 19'd0, 26'd0, 32'h91001423, 1);
    send(4'd2, 5'd2, 5'd19, 5'd30, 6'd0, 12'd0, 9'd0, 19'd0, 26'd0, 32'hEB1E0262, 1);
    send(4'd8, 5'd0, 5'd31, 5'd0, 6'd0, 12'd0, 9'd1, 19'd0, 26'd0, 32'hF84013E0, 1);
    do_restart();

    // B, BL, B.cond
    send(4'd3, 5'd0, 5'd0, 5'd0, 6'd0, 12'd0, 9'd0, 19'd0, 26'd1, 32'h14000001, 1);
    send(4'd4, 5'd0, 5'd0, 5'd0, 6'd0, 12'd0, 9'd0, 19'd0, 26'd15, 32'h9400000F, 1);
    send(4'd5, 5'd3, 5'd0, 5'd0, 6'd0, 12'd0, 9'd0, 19'd32, 26'd0, 32'h54000403, 1);
    do_restart();

    // Back-pressure: ADDS held 3 cycles while CBZ waits
    out_ready = 1'b0;
    send(4'd1, 5'd4, 5'd5, 5'd6, 6'd3, 12'd0, 9'd0, 19'd0, 26'd0, 32'hAB060CA4, 1);
    fork
      send(4'd6, 5'd5, 5'd0, 5'd0, 6'd0, 12'd0, 9'd0, 19'd2, 26'd0, 32'hB4000045, 1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          chk("stall_out_data", out_data, 32'hAB060CA4);
          chk("stall_out_addr", {20'd0, out_addr}, 32'd0);
          chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    do_restart();

    // Fill to DEPTH back-to-back: BR, STUR, ADDI, SUBS
    send(4'd7, 5'd0, 5'd30, 5'd0, 6'd0, 12'd0, 9'd0, 19'd0, 26'd0, 32'hD61F03DE, 1);
    send(4'd9, 5'd1, 5'd2, 5'd0, 6'd0, 12'd0, 9'd8, 19'd0, 26'd0, 32'hF8008041, 1);
    send(4'd0, 5'd31, 5'd31, 5'd0, 6'd0, 12'hFFF, 9'd0, 19'd0, 26'd0, 32'h913FFFFF, 1);
    send(4'd2, 5'd0, 5'd0, 5'd0, 6'd63, 12'd0, 9'd0, 19'd0, 26'd0, 32'hEB00FC00, 1);
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; op = 4'd3; imm26 = 26'd7;
    repeat (4) @(posedge clk);
    #1;
    chk("full_hold_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_hold_out_valid", {31'd0, out_valid}, 32'd0);
    chk("full_hold_count", {29'd0, word_count}, 32'd4);
    in_valid = 1'b0;
    do_restart();
    chk("post_restart_full", {31'd0, full}, 32'd0);
    send(4'd3, 5'd0, 5'd0, 5'd0, 6'd0, 12'd0, 9'd0, 19'd0, 26'h3FFFFFF, 32'h17FFFFFF, 1);

    // Illegal op
    send(4'hF, 5'd1, 5'd1, 5'd1, 6'd0, 12'd0, 9'd0, 19'd0, 26'd0, 32'h0, 0);
    chk("err_illegal_pulse", {31'd0, err_illegal}, 32'd1);
    chk("err_sticky_set", {31'd0, err_sticky}, 32'd1);
    @(posedge clk); #1;
    chk("err_illegal_clear", {31'd0, err_illegal}, 32'd0);
    chk("err_sticky_hold", {31'd0, err_sticky}, 32'd1);
    chk("illegal_count", {29'd0, word_count}, 32'd1);

    // Reset while HOLD drops the word
    out_ready = 1'b0;
    send(4'd4, 5'd0, 5'd0, 5'd0, 6'd0, 12'd0, 9'd0, 19'd0, 26'd0, 32'h94000000, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(exp_q.pop_back());
    exp_addr = 0;
    exp_cnt  = 0;
    out_ready = 1'b1;
    chk("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_hold_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_hold_count", {29'd0, word_count}, 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_no_emit", {31'd0, out_valid}, 32'd0);
    send(4'd9, 5'd1, 5'd2, 5'd0, 6'd0, 12'd0, 9'd8, 19'd0, 26'd0, 32'hF8008041, 1);
    drain();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
